control_sequencer: RTL and testbench

//  SAP-1 controller/sequencer: the driving end of the instruction register (IR).

---
 rtl/control_sequencer_pkg.sv | 60 ++++++
 rtl/control_sequencer_ring_counter.sv | 33 +++
 rtl/control_sequencer.sv | 143 ++++++++++++++
 tb/tb_control_sequencer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/control_sequencer_pkg.sv
// SAP-1 shared definitions: opcodes, one-hot T-state encodings and the
// control-word layout used by the sequencer and the datapath.
package sap1_pkg;

    localparam int unsigned T_WIDTH  = 6;
    localparam int unsigned CW_WIDTH = 13;

    // Opcodes carried in the IR high nibble
    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // One-hot ring counter states, bit0 = T1
    localparam logic [T_WIDTH-1:0] T1 = 6'b000001;
    localparam logic [T_WIDTH-1:0] T2 = 6'b000010;
    localparam logic [T_WIDTH-1:0] T3 = 6'b000100;
    localparam logic [T_WIDTH-1:0] T4 = 6'b001000;
    localparam logic [T_WIDTH-1:0] T5 = 6'b010000;
    localparam logic [T_WIDTH-1:0] T6 = 6'b100000;

    // Bit positions of each control inside the packed control word
    localparam int unsigned CW_HALT     = 0;
    localparam int unsigned CW_OUT_LOAD = 1;
    localparam int unsigned CW_ALU_SUB  = 2;
    localparam int unsigned CW_ALU_OUT  = 3;
    localparam int unsigned CW_B_LOAD   = 4;
    localparam int unsigned CW_A_OUT    = 5;
    localparam int unsigned CW_A_LOAD   = 6;
    localparam int unsigned CW_IR_SEND  = 7;
    localparam int unsigned CW_IR_LOAD  = 8;
    localparam int unsigned CW_RAM_OUT  = 9;
    localparam int unsigned CW_MAR_LOAD = 10;
    localparam int unsigned CW_PC_INC   = 11;
    localparam int unsigned CW_PC_OUT   = 12;

    // Field order matches the bit positions above (MSB first)
    typedef struct packed {
        logic pc_out;
        logic pc_inc;
        logic mar_load;
        logic ram_out;
        logic ir_load;
        logic ir_send;
        logic a_load;
        logic a_out;
        logic b_load;
        logic alu_out;
        logic alu_sub;
        logic out_load;
        logic halt;
    } ctrl_word_t;

    // True when exactly one bit of the T-state vector is set
    function automatic logic is_legal_tstate(input logic [T_WIDTH-1:0] s);
        return (s != '0) && ((s & (s - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/control_sequencer_ring_counter.sv
// One-hot ring counter for the T-state sequence. A synchronous restart
// returns to T1, hold freezes the current state, and any non-one-hot
// value is forced back to T1 on the next clock.
module ring_counter
    import sap1_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_restart,
    input  logic               i_hold,
    output logic [T_WIDTH-1:0] o_state
);

    logic [T_WIDTH-1:0] r_state;
    logic               w_legal;

    assign w_legal = is_legal_tstate(r_state);
    assign o_state = r_state;

    // Advance one state per clock; illegal-state recovery beats hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= T1;
        end else if (!w_legal || i_restart) begin
            r_state <= T1;
        end else if (i_hold) begin
            r_state <= r_state;
        end else begin
            r_state <= {r_state[T_WIDTH-2:0], r_state[T_WIDTH-1]};
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// SAP-1 controller/sequencer. Drives the T-state ring counter and decodes
// the registered T-state, the IR opcode and the halt flag into the full
// control word for PC, MAR, RAM, IR, A, B, ALU and OUT.
//
//  state | meaning
//  T1    | fetch: PC onto bus, MAR loads
//  T2    | fetch: PC increments
//  T3    | fetch: RAM onto bus, IR loads
//  T4    | execute 1: operand address / OUT transfer / halt request
//  T5    | execute 2: operand read
//  T6    | execute 3: ALU result into A
module control_sequencer
    import sap1_pkg::*;
#(
    parameter bit SKIP_NOP_STATES = 1'b0
)(
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         opcode,
    output logic [T_WIDTH-1:0] t_state,
    output logic               pc_out,
    output logic               pc_inc,
    output logic               mar_load,
    output logic               ram_out,
    output logic               ir_load,
    output logic               ir_send,
    output logic               a_load,
    output logic               a_out,
    output logic               b_load,
    output logic               alu_out,
    output logic               alu_sub,
    output logic               out_load,
    output logic               halt
);

    logic       r_halted;
    logic       w_halt_req;
    logic       w_mem_op;
    logic       w_alu_op;
    logic       w_restart;
    logic       w_hold;
    ctrl_word_t w_cw;

    assign w_alu_op   = (opcode == OP_ADD) || (opcode == OP_SUB);
    assign w_mem_op   = (opcode == OP_LDA) || w_alu_op;
    assign w_halt_req = (t_state == T4) && (opcode == OP_HLT);

    // Early return only cuts idle tail states; ADD/SUB and HLT never restart.
    assign w_restart = SKIP_NOP_STATES && !r_halted &&
                       (((t_state == T5) && (opcode == OP_LDA)) ||
                        ((t_state == T4) && !w_mem_op && (opcode != OP_HLT)));

    // The state freezes at T4 both on the halting edge and afterwards
    assign w_hold = w_halt_req || r_halted;

    ring_counter u_ring (
        .clk       (clk),
        .rst       (rst),
        .i_restart (w_restart),
        .i_hold    (w_hold),
        .o_state   (t_state)
    );

    // Sticky halt flag, set by the edge that closes T4 of an HLT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_halted <= 1'b0;
        end else if (w_halt_req) begin
            r_halted <= 1'b1;
        end
    end

    // Control word decode from T-state, opcode and halt flag
    always_comb begin
        w_cw = '0;
        if (rst) begin
            w_cw = '0;
        end else if (r_halted) begin
            w_cw.halt = 1'b1;
        end else begin
            case (t_state)
                T1: begin
                    w_cw.pc_out   = 1'b1;
                    w_cw.mar_load = 1'b1;
                end
                T2: begin
                    w_cw.pc_inc = 1'b1;
                end
                T3: begin
                    w_cw.ram_out = 1'b1;
                    w_cw.ir_load = 1'b1;
                end
                T4: begin
                    if (w_mem_op) begin
                        w_cw.ir_send  = 1'b1;
                        w_cw.mar_load = 1'b1;
                    end else if (opcode == OP_OUT) begin
                        w_cw.a_out    = 1'b1;
                        w_cw.out_load = 1'b1;
                    end else if (opcode == OP_HLT) begin
                        w_cw.halt = 1'b1;
                    end
                end
                T5: begin
                    if (opcode == OP_LDA) begin
                        w_cw.ram_out = 1'b1;
                        w_cw.a_load  = 1'b1;
                    end else if (w_alu_op) begin
                        w_cw.ram_out = 1'b1;
                        w_cw.b_load  = 1'b1;
                        // Subtract is set while B loads so the ALU has settled by T6
                        w_cw.alu_sub = (opcode == OP_SUB);
                    end
                end
                T6: begin
                    if (w_alu_op) begin
                        w_cw.alu_out = 1'b1;
                        w_cw.a_load  = 1'b1;
                        w_cw.alu_sub = (opcode == OP_SUB);
                    end
                end
                default: begin
                    w_cw = '0;
                end
            endcase
        end
    end

    assign pc_out   = w_cw.pc_out;
    assign pc_inc   = w_cw.pc_inc;
    assign mar_load = w_cw.mar_load;
    assign ram_out  = w_cw.ram_out;
    assign ir_load  = w_cw.ir_load;
    assign ir_send  = w_cw.ir_send;
    assign a_load   = w_cw.a_load;
    assign a_out    = w_cw.a_out;
    assign b_load   = w_cw.b_load;
    assign alu_out  = w_cw.alu_out;
    assign alu_sub  = w_cw.alu_sub;
    assign out_load = w_cw.out_load;
    assign halt     = w_cw.halt;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: one instance with full execute
// states (d0) and one with early return (d1), sharing clock and reset.
module tb_control_sequencer;

    // Control word packing used only by this bench
    localparam logic [12:0] C_PC_OUT   = 13'h1000;
    localparam logic [12:0] C_PC_INC   = 13'h0800;
    localparam logic [12:0] C_MAR      = 13'h0400;
    localparam logic [12:0] C_RAM_OUT  = 13'h0200;
    localparam logic [12:0] C_IR_LOAD  = 13'h0100;
    localparam logic [12:0] C_IR_SEND  = 13'h0080;
    localparam logic [12:0] C_A_LOAD   = 13'h0040;
    localparam logic [12:0] C_A_OUT    = 13'h0020;
    localparam logic [12:0] C_B_LOAD   = 13'h0010;
    localparam logic [12:0] C_ALU_OUT  = 13'h0008;
    localparam logic [12:0] C_ALU_SUB  = 13'h0004;
    localparam logic [12:0] C_OUT_LOAD = 13'h0002;
    localparam logic [12:0] C_HALT     = 13'h0001;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] opcode0, opcode1;
    logic [5:0] t0, t1;
    logic pc_out0, pc_inc0, mar_load0, ram_out0, ir_load0, ir_send0, a_load0;
    logic a_out0, b_load0, alu_out0, alu_sub0, out_load0, halt0;
    logic pc_out1, pc_inc1, mar_load1, ram_out1, ir_load1, ir_send1, a_load1;
    logic a_out1, b_load1, alu_out1, alu_sub1, out_load1, halt1;
    logic [12:0] cw0, cw1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign cw0 = {pc_out0, pc_inc0, mar_load0, ram_out0, ir_load0, ir_send0, a_load0,
                  a_out0, b_load0, alu_out0, alu_sub0, out_load0, halt0};
    assign cw1 = {pc_out1, pc_inc1, mar_load1, ram_out1, ir_load1, ir_send1, a_load1,
                  a_out1, b_load1, alu_out1, alu_sub1, out_load1, halt1};

    control_sequencer #(.SKIP_NOP_STATES(1'b0)) d0 (
        .clk(clk), .rst(rst), .opcode(opcode0), .t_state(t0),
        .pc_out(pc_out0), .pc_inc(pc_inc0), .mar_load(mar_load0), .ram_out(ram_out0),
        .ir_load(ir_load0), .ir_send(ir_send0), .a_load(a_load0), .a_out(a_out0),
        .b_load(b_load0), .alu_out(alu_out0), .alu_sub(alu_sub0), .out_load(out_load0),
        .halt(halt0)
    );

    control_sequencer #(.SKIP_NOP_STATES(1'b1)) d1 (
        .clk(clk), .rst(rst), .opcode(opcode1), .t_state(t1),
        .pc_out(pc_out1), .pc_inc(pc_inc1), .mar_load(mar_load1), .ram_out(ram_out1),
        .ir_load(ir_load1), .ir_send(ir_send1), .a_load(a_load1), .a_out(a_out1),
        .b_load(b_load1), .alu_out(alu_out1), .alu_sub(alu_sub1), .out_load(out_load1),
        .halt(halt1)
    );

    task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Bus-driver exclusivity and IR load/send exclusion, every cycle, both instances
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            chk("bus_drivers_d0",
                13'(int'(pc_out0) + int'(ram_out0) + int'(ir_send0) + int'(a_out0) + int'(alu_out0) > 1),
                13'd0);
            chk("bus_drivers_d1",
                13'(int'(pc_out1) + int'(ram_out1) + int'(ir_send1) + int'(a_out1) + int'(alu_out1) > 1),
                13'd0);
            chk("ir_load_send_d0", {12'd0, ir_load0 & ir_send0}, 13'd0);
            chk("ir_load_send_d1", {12'd0, ir_load1 & ir_send1}, 13'd0);
        end
    end

    initial begin
        rst = 1'b1;
        opcode0 = 4'h0;
        opcode1 = 4'h0;
        #12;
        chk("reset_t0", {7'd0, t0}, 13'h001);
        chk("reset_cw0", cw0, 13'h0);
        chk("reset_cw1", cw1, 13'h0);
        rst = 1'b0;
        #1;
        chk("t1_after_reset_cw0", cw0, C_PC_OUT | C_MAR);

        // LDA, full execute
        tick(); chk("lda_t2", cw0, C_PC_INC);
        tick(); chk("lda_t3", cw0, C_RAM_OUT | C_IR_LOAD);
        tick(); chk("lda_t4_state", {7'd0, t0}, 13'h008);
                chk("lda_t4", cw0, C_IR_SEND | C_MAR);
        tick(); chk("lda_t5", cw0, C_RAM_OUT | C_A_LOAD);
        tick(); chk("lda_t6_state", {7'd0, t0}, 13'h020);
                chk("lda_t6", cw0, 13'h0);
        tick(); chk("lda_wrap_state", {7'd0, t0}, 13'h001);

        // SUB
        opcode0 = 4'h2;
        tick(); tick(); tick();
        chk("sub_t4", cw0, C_IR_SEND | C_MAR);
        tick(); chk("sub_t5", cw0, C_RAM_OUT | C_B_LOAD | C_ALU_SUB);
        tick(); chk("sub_t6", cw0, C_ALU_OUT | C_A_LOAD | C_ALU_SUB);
        tick(); chk("sub_wrap_state", {7'd0, t0}, 13'h001);

        // ADD aborted by reset during T5
        opcode0 = 4'h1;
        tick(); tick(); tick(); tick();
        chk("add_t5", cw0, C_RAM_OUT | C_B_LOAD);
        rst = 1'b1;
        #1;
        chk("abort_state", {7'd0, t0}, 13'h001);
        chk("abort_cw0", cw0, 13'h0);
        tick();
        chk("abort_hold_state", {7'd0, t0}, 13'h001);
        chk("abort_hold_cw0", cw0, 13'h0);
        rst = 1'b0;
        #1;
        chk("abort_release_cw0", cw0, C_PC_OUT | C_MAR);
        tick(); chk("abort_t2", cw0, C_PC_INC);

        // HLT
        opcode0 = 4'hF;
        tick(); tick();
        chk("hlt_t4_state", {7'd0, t0}, 13'h008);
        chk("hlt_t4", cw0, C_HALT);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("halted_state", {7'd0, t0}, 13'h008);
            chk("halted_cw", cw0, C_HALT);
        end
        opcode0 = 4'h1;
        tick();
        chk("halted_opchange_cw", cw0, C_HALT);
        chk("halted_opchange_state", {7'd0, t0}, 13'h008);
        rst = 1'b1;
        #1;
        chk("hlt_reset_state", {7'd0, t0}, 13'h001);
        rst = 1'b0;
        #1;
        chk("hlt_reset_cw0", cw0, C_PC_OUT | C_MAR);

        // Early return on d1; d0 runs a NOP through all execute states
        opcode0 = 4'h7;
        opcode1 = 4'hE;
        tick(); tick(); tick();
        chk("out_t4_state", {7'd0, t1}, 13'h008);
        chk("out_t4", cw1, C_A_OUT | C_OUT_LOAD);
        chk("nop_full_t4", cw0, 13'h0);
        tick();
        chk("out_return_state", {7'd0, t1}, 13'h001);
        chk("nop_full_t5_state", {7'd0, t0}, 13'h010);
        opcode1 = 4'h7;
        tick();
        chk("nop_full_t6_state", {7'd0, t0}, 13'h020);
        chk("nop_full_t6", cw0, 13'h0);
        tick();
        chk("nop_full_wrap", {7'd0, t0}, 13'h001);
        tick();
        chk("nop_skip_t4_state", {7'd0, t1}, 13'h008);
        chk("nop_skip_t4", cw1, 13'h0);
        tick();
        chk("nop_skip_return", {7'd0, t1}, 13'h001);

        opcode1 = 4'h0;
        tick(); tick(); tick(); tick();
        chk("lda_skip_t5", cw1, C_RAM_OUT | C_A_LOAD);
        tick();
        chk("lda_skip_return", {7'd0, t1}, 13'h001);

        opcode1 = 4'h1;
        tick(); tick(); tick(); tick(); tick();
        chk("add_skip_t6_state", {7'd0, t1}, 13'h020);
        chk("add_skip_t6", cw1, C_ALU_OUT | C_A_LOAD);
        tick();
        chk("add_skip_wrap", {7'd0, t1}, 13'h001);

        // Illegal T-state recovery
        force d0.u_ring.r_state = 6'b000011;
        #1;
        release d0.u_ring.r_state;
        #1;
        chk("illegal_state_forced", {7'd0, t0}, 13'h003);
        tick();
        chk("illegal_recover", {7'd0, t0}, 13'h001);
        chk("illegal_recover_cw", cw0, C_PC_OUT | C_MAR);

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
